multicycle_control_unit: RTL
============================

# multicycle_control_unit

Multicycle successor to the single-cycle instruction decoder. It sequences each RISC-V instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK states and drives the datapath control strobes per state. It waits on a shared memory ready handshake, traps on illegal opcodes and memory timeouts, and counts retired instructions. It sits between the instruction register and the multicycle datapath, which has a single memory port.

## Interface
- `ALU_OP_W`, default 2: width of `alu_op`. Encodings are ADD=0, SUB=1, R_TYPE=2, zero-extended to this width.
- `TIMEOUT_CYC`, default 0: maximum number of cycles to wait for `mem_ready`. The value 0 disables the timeout.
- `CNT_W`, default 32: width of the retired-instruction counter.
- `clk` input, 1 bit: the single clock.
- `arst_n` input, 1 bit: synchronous active-low reset, sampled on the rising edge of `clk`.
- `opcode` input, 7 bits: opcode field of the instruction register.
- `mem_ready` input, 1 bit: memory has completed the current read or write.
- `pc_write`, `ir_write`, `mem_read`, `mem_write`, `mem_2_reg`, `alu_src`, `reg_write`, `branch`, `jump` outputs, 1 bit each: datapath strobes.
- `alu_op` output, `ALU_OP_W` bits: ALU operation class.
- `instr_done` output, 1 bit: one-cycle pulse on the last cycle of each instruction.
- `trap` output, 1 bit: sticky flag, set on an illegal opcode or a memory timeout.
- `trap_cause` output, 1 bit: 0 = illegal opcode, 1 = memory timeout.
- `retired` output, `CNT_W` bits: number of retired instructions.

## Operation
- The supported opcodes are ALU_R 0110011, ALU_I 0010011, BRANCH_EQ 1100011, JUMP 1101111, LOAD_WORD 0000011 and STORE_WORD 0100011.
- States are IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK and TRAP. The state register and all internal registers are clocked.
- Outputs are a combinational decode of the current state and the latched opcode `op_q`. Every strobe not listed for a state is 0, and `alu_op` is 0 unless stated otherwise.
- **IDLE:** all outputs 0. Goes unconditionally to FETCH on the next cycle.
- **FETCH:** `mem_read`=1.
  - While `mem_ready`=0, stay in FETCH.
  - On the cycle `mem_ready`=1: `ir_write`=1 and `pc_write`=1, then go to DECODE.
- **DECODE:** latch `opcode` into `op_q`.
  - If the opcode is legal, go to EXECUTE.
  - Otherwise go to TRAP with `trap_cause`=0.
- **EXECUTE:** behaviour depends on `op_q`.
  - ALU_R: `alu_src`=0, `alu_op`=R_TYPE. Go to WRITEBACK.
  - ALU_I: `alu_src`=1, `alu_op`=ADD. Go to WRITEBACK.
  - LOAD_WORD and STORE_WORD: `alu_src`=1, `alu_op`=ADD. Go to MEMORY.
  - BRANCH_EQ: `branch`=1, `alu_op`=SUB, `instr_done`=1. Go to FETCH.
  - JUMP: `jump`=1, `alu_op`=R_TYPE, `instr_done`=1. Go to FETCH.
- **MEMORY:** `alu_src`=1 is held.
  - LOAD_WORD drives `mem_read`=1. When `mem_ready`=1, go to WRITEBACK.
  - STORE_WORD drives `mem_write`=1. When `mem_ready`=1, pulse `instr_done` and go to FETCH.
- **WRITEBACK:** `reg_write`=1, and `mem_2_reg`=1 only for LOAD_WORD. `instr_done`=1. Go to FETCH.
- **TRAP:** all strobes 0 and `trap`=1. The block stays in TRAP until reset.
- **Retired counter:** `retired` increments on every cycle where `instr_done`=1. It wraps modulo 2^`CNT_W`.
- **Wait counter:** counts consecutive cycles in a state waiting on memory (FETCH, or MEMORY for loads and stores) while `mem_ready`=0. It clears on any state change.
  - When `TIMEOUT_CYC`>0 and the wait counter reaches `TIMEOUT_CYC` with `mem_ready` still 0, go to TRAP with `trap_cause`=1.
  - If `mem_ready`=1 arrives on the same cycle the timeout would fire, the handshake wins and no trap is taken.

## Timing
- **Reset:** while `arst_n`=0 at a clock edge, the next state is IDLE, `op_q`=0, `retired`=0, the wait counter is 0, `trap`=0 and `trap_cause`=0.
  - All outputs are 0 in IDLE.
  - Reset asserted in any state, including TRAP or mid-wait, aborts the instruction with no `instr_done` pulse.
- **Latency with zero memory wait states** (`mem_ready` high in the first cycle of each wait):
  - Branch and jump: 3 cycles (FETCH, DECODE, EXECUTE).
  - R-type, I-type and store: 4 cycles.
  - Load: 5 cycles.
  - Each extra cycle with `mem_ready`=0 adds one cycle.
- **Memory handshake:** `mem_read`/`mem_write` stay asserted and stable until the cycle `mem_ready` is sampled high. The transfer completes in that cycle.
  - `mem_ready` is ignored in every state other than FETCH and MEMORY.
- **Opcode timing:** `opcode` is sampled only in DECODE. Changes to it at any other time have no effect.
- **Trap timing:** `trap` rises in the cycle after the offending DECODE, or in the cycle after the timeout expires.

## Structure
- Shared package `cpu_ctrl_pkg` holds:
  - the opcode constants;
  - the `alu_op` encodings ADD/SUB/R_TYPE;
  - the state enum;
  - the trap cause constants.
- One sub-module: `wait_timer`, a wait counter with clear, enable and an expired output, parametrised by `TIMEOUT_CYC`.

## Test plan
- **Reset, then R-type:** hold `arst_n` low for 2 cycles, then release with `opcode`=0110011 and `mem_ready`=1.
  - During reset: all outputs 0.
  - After release, the states run IDLE, FETCH, DECODE, EXECUTE (`alu_op`=2), WRITEBACK (`reg_write`=1).
  - `instr_done` pulses once and `retired`=1.
- **Load with 3 wait states in MEMORY:**
  - `mem_read` is held for 4 cycles in MEMORY.
  - In WRITEBACK, `mem_2_reg`=1.
  - Total of 8 cycles from FETCH to `instr_done`.
- **BEQ then JAL back-to-back:**
  - `branch`=1 with `alu_op`=1 for exactly 1 cycle, then `jump`=1 for exactly 1 cycle.
  - Each instruction takes 3 cycles and `retired` reaches 2.
- **Illegal opcode 1111111:** `trap`=1 and `trap_cause`=0 the cycle after DECODE. The block stays in TRAP for 20+ cycles with all strobes 0. An `arst_n` pulse returns it to IDLE.
- **Memory timeout:** with `TIMEOUT_CYC`=4, hold `mem_ready`=0 during a store. Expect `trap`=1 and `trap_cause`=1 with no `instr_done`.
  - Repeat with `mem_ready` rising exactly on the 4th wait cycle: no trap is taken.
- **Counter wrap:** with `CNT_W`=3, retire 9 instructions. `retired` steps through 7, 0, 1.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_ctrl_pkg
// Description : Shared opcode, ALU-class, state and trap-cause definitions
//               for the multicycle control unit.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_ctrl_pkg;

  // Supported RISC-V major opcodes
  localparam logic [6:0] c_OP_ALU_R      = 7'b0110011;
  localparam logic [6:0] c_OP_ALU_I      = 7'b0010011;
  localparam logic [6:0] c_OP_BRANCH_EQ  = 7'b1100011;
  localparam logic [6:0] c_OP_JUMP       = 7'b1101111;
  localparam logic [6:0] c_OP_LOAD_WORD  = 7'b0000011;
  localparam logic [6:0] c_OP_STORE_WORD = 7'b0100011;

  // ALU operation classes (zero-extended to the port width at the top)
  localparam logic [1:0] c_ALU_ADD    = 2'd0;
  localparam logic [1:0] c_ALU_SUB    = 2'd1;
  localparam logic [1:0] c_ALU_R_TYPE = 2'd2;

  // Trap causes
  localparam logic c_TRAP_ILLEGAL = 1'b0;
  localparam logic c_TRAP_TIMEOUT = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEMORY    = 3'd4,
    S_WRITEBACK = 3'd5,
    S_TRAP      = 3'd6
  } state_e;

  function automatic logic is_legal_opcode(input logic [6:0] op);
    return (op == c_OP_ALU_R)     || (op == c_OP_ALU_I)      ||
           (op == c_OP_BRANCH_EQ) || (op == c_OP_JUMP)       ||
           (op == c_OP_LOAD_WORD) || (op == c_OP_STORE_WORD);
  endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_control_unit_wait_timer.sv
`default_nettype none
// ============================================================================
// Module      : wait_timer
// Description : Counts consecutive memory-wait cycles. expired asserts on the
//               TIMEOUT_CYC-th consecutive wait cycle; TIMEOUT_CYC=0 disables.
// Revision    : 1.0 - initial release
// ============================================================================
module wait_timer #(
  parameter int unsigned TIMEOUT_CYC = 0
) (
  input  logic clk,
  input  logic arst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  // Count value seen on the last allowed wait cycle (count holds prior waits)
  localparam logic [CW-1:0] c_LAST = CW'((TIMEOUT_CYC > 0) ? (TIMEOUT_CYC - 1) : 0);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Next count: clear on request, otherwise saturating increment while waiting
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != '1)) begin
      count_d = count_q + CW'(1);
    end
  end

  // Count register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Fires only while still waiting, so a same-cycle handshake suppresses it
  assign expired = (TIMEOUT_CYC != 0) && en && (count_q == c_LAST);

endmodule
`default_nettype wire

// File: rtl/multicycle_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control_unit
// Description : Sequences RISC-V instructions through FETCH/DECODE/EXECUTE/
//               MEMORY/WRITEBACK, drives datapath strobes, traps on illegal
//               opcodes and memory timeouts, counts retired instructions.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned ALU_OP_W    = 2,
  parameter int unsigned TIMEOUT_CYC = 0,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                clk,
  input  logic                arst_n,
  input  logic [6:0]          opcode,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                ir_write,
  output logic                mem_read,
  output logic                mem_write,
  output logic                mem_2_reg,
  output logic                alu_src,
  output logic                reg_write,
  output logic                branch,
  output logic                jump,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                instr_done,
  output logic                trap,
  output logic                trap_cause,
  output logic [CNT_W-1:0]    retired
);

  state_e           state_q, state_d;
  logic [6:0]       op_q, op_d;
  logic             trap_q, trap_d;
  logic             cause_q, cause_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  logic w_waiting;
  logic w_tmr_en;
  logic w_tmr_clr;
  logic w_tmr_expired;

  // Memory waits happen only in FETCH and MEMORY; any state change restarts the count
  assign w_waiting = (state_q == S_FETCH) || (state_q == S_MEMORY);
  assign w_tmr_en  = w_waiting && !mem_ready;
  assign w_tmr_clr = !w_waiting || (state_d != state_q);

  wait_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_wait_timer (
    .clk     (clk),
    .arst_n  (arst_n),
    .clr     (w_tmr_clr),
    .en      (w_tmr_en),
    .expired (w_tmr_expired)
  );

  // Next-state, strobe decode and retire-counter update for the current state
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    trap_d     = trap_q;
    cause_d    = cause_q;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_2_reg  = 1'b0;
    alu_src    = 1'b0;
    reg_write  = 1'b0;
    branch     = 1'b0;
    jump       = 1'b0;
    alu_op     = '0;
    instr_done = 1'b0;

    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
      end

      S_FETCH: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end else if (w_tmr_expired) begin
          state_d = S_TRAP;
          trap_d  = 1'b1;
          cause_d = c_TRAP_TIMEOUT;
        end
      end

      S_DECODE: begin
        op_d = opcode;
        if (is_legal_opcode(opcode)) begin
          state_d = S_EXECUTE;
        end else begin
          state_d = S_TRAP;
          trap_d  = 1'b1;
          cause_d = c_TRAP_ILLEGAL;
        end
      end

      S_EXECUTE: begin
        case (op_q)
          c_OP_ALU_R: begin
            alu_op  = ALU_OP_W'(c_ALU_R_TYPE);
            state_d = S_WRITEBACK;
          end
          c_OP_ALU_I: begin
            alu_src = 1'b1;
            alu_op  = ALU_OP_W'(c_ALU_ADD);
            state_d = S_WRITEBACK;
          end
          c_OP_LOAD_WORD, c_OP_STORE_WORD: begin
            alu_src = 1'b1;
            alu_op  = ALU_OP_W'(c_ALU_ADD);
            state_d = S_MEMORY;
          end
          c_OP_BRANCH_EQ: begin
            branch     = 1'b1;
            alu_op     = ALU_OP_W'(c_ALU_SUB);
            instr_done = 1'b1;
            state_d    = S_FETCH;
          end
          c_OP_JUMP: begin
            jump       = 1'b1;
            alu_op     = ALU_OP_W'(c_ALU_R_TYPE);
            instr_done = 1'b1;
            state_d    = S_FETCH;
          end
          default: begin
            // op_q was checked in DECODE; an unknown value here is a fault
            state_d = S_TRAP;
            trap_d  = 1'b1;
            cause_d = c_TRAP_ILLEGAL;
          end
        endcase
      end

      S_MEMORY: begin
        alu_src = 1'b1;
        if (op_q == c_OP_STORE_WORD) begin
          mem_write = 1'b1;
        end else begin
          mem_read = 1'b1;
        end
        if (mem_ready) begin
          if (op_q == c_OP_STORE_WORD) begin
            instr_done = 1'b1;
            state_d    = S_FETCH;
          end else begin
            state_d = S_WRITEBACK;
          end
        end else if (w_tmr_expired) begin
          state_d = S_TRAP;
          trap_d  = 1'b1;
          cause_d = c_TRAP_TIMEOUT;
        end
      end

      S_WRITEBACK: begin
        reg_write  = 1'b1;
        mem_2_reg  = (op_q == c_OP_LOAD_WORD);
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end

      S_TRAP: begin
        state_d = S_TRAP;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    retired_d = retired_q + CNT_W'(instr_done);
  end

  // State and bookkeeping registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      trap_q    <= 1'b0;
      cause_q   <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      trap_q    <= trap_d;
      cause_q   <= cause_d;
      retired_q <= retired_d;
    end
  end

  assign trap       = trap_q;
  assign trap_cause = cause_q;
  assign retired    = retired_q;

endmodule
`default_nettype wire
